// File: rtl/regfile_arbiter.sv
// Three-requester round-robin arbiter (r0 write, r1 write, rd read) in front of a single-port register file.
// Optional macro REGFILE_WPROT_EN blocks r1 writes to addresses 0-15 and flags them on r1_err.
module regfile_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  input  logic              r1_req,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_err,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout
);

  // IDLE: arbitrate | WR: one write cycle | RD: present read address | RDW: capture mem_dout
  typedef enum logic [1:0] {IDLE, WR, RD, RDW} state_t;

  state_t            r_state;
  logic [1:0]        r_last;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_din;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_mem_we;
  logic              r_r0_gnt;
  logic              r_r1_gnt;
  logic              r_rd_gnt;
  logic              r_rd_valid;
  logic              r_r1_err;

  logic              w_any;
  logic              w_prot;
  logic [1:0]        w_win;

  assign w_any = r0_req | r1_req | rd_req;

  // Search order starts one past the last granted requester (0=r0, 1=r1, 2=rd).
  always_comb begin
    w_win = 2'd0;
    case (r_last)
      2'd0: begin
        if (r1_req)      w_win = 2'd1;
        else if (rd_req) w_win = 2'd2;
        else             w_win = 2'd0;
      end
      2'd1: begin
        if (rd_req)      w_win = 2'd2;
        else if (r0_req) w_win = 2'd0;
        else             w_win = 2'd1;
      end
      default: begin
        if (r0_req)      w_win = 2'd0;
        else if (r1_req) w_win = 2'd1;
        else             w_win = 2'd2;
      end
    endcase
  end

`ifdef REGFILE_WPROT_EN
  assign w_prot = (32'(r1_addr) < 32'd16);
`else
  assign w_prot = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_last     <= 2'd2;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_rd_data  <= '0;
      r_mem_we   <= 1'b0;
      r_r0_gnt   <= 1'b0;
      r_r1_gnt   <= 1'b0;
      r_rd_gnt   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_r1_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_rd_valid <= 1'b0;
          if (w_any) begin
            r_last <= w_win;
            case (w_win)
              2'd0: begin
                r_mem_addr <= r0_addr;
                r_mem_din  <= r0_wdata;
                r_mem_we   <= 1'b1;
                r_r0_gnt   <= 1'b1;
                r_state    <= WR;
              end
              2'd1: begin
                r_mem_addr <= r1_addr;
                r_mem_din  <= r1_wdata;
                r_mem_we   <= ~w_prot;
                r_r1_err   <= w_prot;
                r_r1_gnt   <= 1'b1;
                r_state    <= WR;
              end
              default: begin
                r_mem_addr <= rd_addr;
                r_mem_we   <= 1'b0;
                r_state    <= RD;
              end
            endcase
          end
        end
        WR: begin
          r_mem_we <= 1'b0;
          r_r0_gnt <= 1'b0;
          r_r1_gnt <= 1'b0;
          r_r1_err <= 1'b0;
          r_state  <= IDLE;
        end
        RD: begin
          r_rd_gnt <= 1'b1;
          r_state  <= RDW;
        end
        RDW: begin
          r_rd_gnt   <= 1'b0;
          r_rd_data  <= mem_dout;
          r_rd_valid <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign r0_gnt   = r_r0_gnt;
  assign r1_gnt   = r_r1_gnt;
  assign r1_err   = r_r1_err;
  assign rd_gnt   = r_rd_gnt;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign mem_addr = r_mem_addr;
  assign mem_din  = r_mem_din;
  assign mem_we   = r_mem_we;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: directed scenarios then random traffic, checked against a transaction-level model.
module tb_regfile_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       r0_req, r1_req, rd_req;
  logic [4:0] r0_addr, r1_addr, rd_addr;
  logic [7:0] r0_wdata, r1_wdata;
  logic       r0_gnt, r1_gnt, r1_err, rd_gnt, rd_valid, mem_we;
  logic [7:0] rd_data, mem_din;
  logic [7:0] mem_dout = 8'h00;
  logic [4:0] mem_addr;

  regfile_arbiter #(.ADDR_W(5), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_gnt(r0_gnt),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_err(r1_err),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_data(rd_data), .rd_valid(rd_valid),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // register file with one-cycle read latency
  logic [7:0] tb_mem [32];
  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr] <= mem_din;
    mem_dout <= tb_mem[mem_addr];
  end

  typedef struct {
    logic       g0, g1, gr, we, err, valid, chka;
    logic [4:0] addr;
    logic [7:0] din, rdata;
  } exp_t;

  exp_t       sched [4];
  logic [7:0] mdl_mem [32];
  int         m_last, m_busy;
  logic [7:0] m_rdata;
  logic       act [3];
  logic       won [3];
  logic       fresh [3];
  logic [4:0] q_addr [3];
  logic [7:0] q_data [3];
  int         t_issue [3];
  int         gcnt [3];
  int         nassert = 0, nfail = 0;
  int         cyc = 0, last_wr = -1;
  logic       alt_ok = 1'b1;
  bit         rnd_mode = 0, hold_mode = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    nassert++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic issue(int i, logic [4:0] a, logic [7:0] d);
    act[i] = 1'b1; won[i] = 1'b0; fresh[i] = 1'b1;
    q_addr[i] = a; q_data[i] = d;
  endtask

  task automatic drive();
    r0_req = act[0]; r0_addr = q_addr[0]; r0_wdata = q_data[0];
    r1_req = act[1]; r1_addr = q_addr[1]; r1_wdata = q_data[1];
    rd_req = act[2]; rd_addr = q_addr[2];
  endtask

  task automatic model_reset();
    m_last = 2; m_busy = 0; m_rdata = 8'h00;
    for (int i = 0; i < 4; i++) sched[i] = '{default: '0};
    for (int i = 0; i < 3; i++) begin act[i] = 1'b0; won[i] = 1'b0; fresh[i] = 1'b0; end
    drive();
  endtask

  // Pick the next pending requester after the last winner and schedule its transaction.
  task automatic arbitrate();
    int   w, idx;
    logic prot;
    w = -1;
    for (int k = 1; k <= 3; k++) begin
      idx = (m_last + k) % 3;
      if (act[idx] && w < 0) w = idx;
    end
    if (w < 0) return;
    m_last = w; won[w] = 1'b1;
    if (w == 2) begin
      sched[0].chka = 1'b1; sched[0].addr = q_addr[2];
      sched[1].chka = 1'b1; sched[1].addr = q_addr[2]; sched[1].gr = 1'b1;
      sched[2].valid = 1'b1; sched[2].rdata = mdl_mem[q_addr[2]];
      m_busy = 2;
    end else begin
`ifdef REGFILE_WPROT_EN
      prot = (w == 1) && (q_addr[1] < 5'd16);
`else
      prot = 1'b0;
`endif
      sched[0].chka = 1'b1; sched[0].addr = q_addr[w]; sched[0].din = q_data[w];
      sched[0].we = ~prot; sched[0].err = prot;
      sched[0].g0 = (w == 0); sched[0].g1 = (w == 1);
      m_busy = 1;
    end
  endtask

  task automatic step();
    exp_t e;
    logic g;
    @(negedge clk);
    cyc++;
    e = sched[0];
    for (int i = 0; i < 3; i++) sched[i] = sched[i+1];
    sched[3] = '{default: '0};
    if (e.valid) m_rdata = e.rdata;
    if (e.we) mdl_mem[e.addr] = e.din;
    chk("r0_gnt", r0_gnt, e.g0);
    chk("r1_gnt", r1_gnt, e.g1);
    chk("rd_gnt", rd_gnt, e.gr);
    chk("mem_we", mem_we, e.we);
    chk("r1_err", r1_err, e.err);
    chk("rd_valid", rd_valid, e.valid);
    chk("rd_data", rd_data, m_rdata);
    chk("gnt_onehot", 32'(int'(r0_gnt) + int'(r1_gnt) + int'(rd_gnt) <= 1), 1);
    if (e.chka) chk("mem_addr", mem_addr, e.addr);
    if (e.g0 || e.g1) chk("mem_din", mem_din, e.din);
    for (int i = 0; i < 3; i++) begin
      g = (i == 0) ? e.g0 : (i == 1) ? e.g1 : e.gr;
      if (g) begin
        chk("grant_latency", 32'((cyc - t_issue[i]) <= 8), 1);
        act[i] = 1'b0; won[i] = 1'b0; gcnt[i]++;
        if (i < 2) begin
          if (last_wr == i) alt_ok = 1'b0;
          last_wr = i;
          if (hold_mode) issue(i, 5'($urandom), 8'($urandom));
        end
      end
    end
    if (rnd_mode) begin
      for (int i = 0; i < 3; i++) begin
        if (!act[i] && $urandom_range(2) == 0) issue(i, 5'($urandom), 8'($urandom));
        else if (act[i] && !won[i] && $urandom_range(15) == 0) act[i] = 1'b0;
      end
    end
    for (int i = 0; i < 3; i++) if (fresh[i]) begin t_issue[i] = cyc; fresh[i] = 1'b0; end
    drive();
    if (m_busy > 0) m_busy--;
    else arbitrate();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      tb_mem[i]  = 8'(i * 37 + 5);
      mdl_mem[i] = 8'(i * 37 + 5);
    end
    for (int i = 0; i < 3; i++) begin q_addr[i] = '0; q_data[i] = '0; t_issue[i] = 0; gcnt[i] = 0; end
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_r0_gnt", r0_gnt, 0);
    chk("rst_r1_gnt", r1_gnt, 0);
    chk("rst_rd_gnt", rd_gnt, 0);
    chk("rst_r1_err", r1_err, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din", mem_din, 0);
    @(negedge clk);
    reset = 1'b1;

    // all three right after reset: r0, r1, rd in order, rd_valid 7 cycles after first sample
    issue(0, 5'd1, 8'h11); issue(1, 5'd2, 8'h22); issue(2, 5'd1, 8'h00);
    step();
    repeat (7) step();
    chk("all3_rd_valid", rd_valid, 1);
    chk("all3_rd_data", rd_data, 8'h11);

    issue(0, 5'd5, 8'hA7);
    step(); step();
    chk("wr5_we", mem_we, 1);
    chk("wr5_addr", mem_addr, 5);
    chk("wr5_din", mem_din, 8'hA7);
    chk("wr5_gnt", r0_gnt, 1);

    issue(0, 5'd31, 8'h3C);
    step(); step();
    issue(2, 5'd31, 8'h00);
    repeat (4) step();
    chk("rd31_valid", rd_valid, 1);
    chk("rd31_data", rd_data, 8'h3C);

`ifdef REGFILE_WPROT_EN
    issue(1, 5'd3, 8'h55);
    step(); step();
    chk("prot_gnt", r1_gnt, 1);
    chk("prot_err", r1_err, 1);
    chk("prot_we", mem_we, 0);
    issue(1, 5'd20, 8'h66);
    step(); step();
    chk("unprot_we", mem_we, 1);
    chk("unprot_err", r1_err, 0);
`else
    issue(1, 5'd3, 8'h55);
    step(); step();
    chk("r1_low_we", mem_we, 1);
    chk("r1_low_err", r1_err, 0);
`endif

    // reset pulled low in the middle of a write
    issue(0, 5'd9, 8'h99);
    step();
    @(posedge clk);
    #2;
    chk("midwr_we_before", mem_we, 1);
    reset = 1'b0;
    #1;
    chk("midwr_we_after", mem_we, 0);
    chk("midwr_gnt_after", r0_gnt, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    issue(1, 5'd10, 8'h5A); issue(0, 5'd11, 8'hA5);
    step(); step();
    chk("post_rst_r0_first", r0_gnt, 1);
    step(); step();
    chk("post_rst_r1_next", r1_gnt, 1);

    // r0 and r1 held continuously
    hold_mode = 1; alt_ok = 1'b1; last_wr = -1;
    for (int i = 0; i < 3; i++) gcnt[i] = 0;
    issue(0, 5'($urandom), 8'($urandom)); issue(1, 5'($urandom), 8'($urandom));
    repeat (40) step();
    hold_mode = 0;
    chk("hold_alternate", alt_ok, 1);
    chk("hold_r0_count", gcnt[0], 10);
    chk("hold_r1_count", gcnt[1], 10);
    repeat (6) step();

    rnd_mode = 1;
    repeat (1500) step();
    rnd_mode = 0;
    repeat (12) step();

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
